// File: rtl/dds_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for a DDS phase accumulator.
// Drives the tuning word through single, sawtooth or triangle sweeps.
module dds_sweep_ctrl #(
    parameter int W  = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  f_start,
    input  logic [W-1:0]  f_stop,
    input  logic [W-1:0]  f_step,
    input  logic [DW-1:0] dwell,
    output logic [W-1:0]  inc,
    output logic          inc_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          dir
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        SW_SINGLE,
        SW_SAW,
        SW_TRI
    } sweep_t;

    state_t         state, state_n;

    sweep_t         sweep_in, cfg_sweep;
    logic [W-1:0]   cfg_start, cfg_stop, cfg_step;
    logic [DW-1:0]  cfg_dwell_m1, dwell_m1_in;
    logic           cfg_ok, cfg_load;

    logic [DW-1:0]  cnt, cnt_n;
    logic [W-1:0]   inc_n;
    logic           inc_valid_n, busy_n, done_n, err_n, dir_n;

    logic [W:0]     up_sum, dn_diff;
    logic [W-1:0]   up_tone, dn_tone;

    always_comb begin
        case (mode)
            2'b01:   sweep_in = SW_SAW;
            2'b10:   sweep_in = SW_TRI;
            default: sweep_in = SW_SINGLE;
        endcase
    end

    // The dwell counter runs down to zero, so a dwell of 0 behaves like 1.
    assign dwell_m1_in = (dwell == '0) ? '0 : dwell - DW'(1);
    assign cfg_ok      = (f_step != '0) && (f_start <= f_stop);

    // Steps are evaluated one bit wider so a carry or borrow clamps to the endpoint.
    assign up_sum  = {1'b0, inc} + {1'b0, cfg_step};
    assign up_tone = (up_sum > {1'b0, cfg_stop}) ? cfg_stop : up_sum[W-1:0];
    assign dn_diff = {1'b0, inc} - {1'b0, cfg_step};
    assign dn_tone = (dn_diff[W] || (dn_diff[W-1:0] < cfg_start)) ? cfg_start : dn_diff[W-1:0];

    // NOTE: every next-value signal is defaulted first so no path leaves one unassigned (no latch).
    always_comb begin
        state_n     = state;
        inc_n       = inc;
        inc_valid_n = inc_valid;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = 1'b0;
        dir_n       = dir;
        cnt_n       = cnt;
        cfg_load    = 1'b0;

        if (abort) begin
            state_n     = S_IDLE;
            inc_n       = '0;
            inc_valid_n = 1'b0;
            busy_n      = 1'b0;
            dir_n       = 1'b1;
            cnt_n       = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            cfg_load    = 1'b1;
                            state_n     = S_RUN;
                            inc_n       = f_start;
                            inc_valid_n = 1'b1;
                            busy_n      = 1'b1;
                            dir_n       = 1'b1;
                            cnt_n       = dwell_m1_in;
                        end else begin
                            done_n = 1'b1;
                            err_n  = 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (cnt != '0) begin
                        cnt_n = cnt - DW'(1);
                    end else begin
                        cnt_n = cfg_dwell_m1;
                        if (dir) begin
                            if (inc == cfg_stop) begin
                                case (cfg_sweep)
                                    SW_SAW: inc_n = cfg_start;
                                    SW_TRI: begin
                                        // A degenerate triangle just holds its single tone.
                                        if (cfg_start != cfg_stop) begin
                                            dir_n = 1'b0;
                                            inc_n = dn_tone;
                                        end
                                    end
                                    default: begin
                                        state_n     = S_IDLE;
                                        inc_n       = '0;
                                        inc_valid_n = 1'b0;
                                        busy_n      = 1'b0;
                                        done_n      = 1'b1;
                                        cnt_n       = '0;
                                    end
                                endcase
                            end else begin
                                inc_n = up_tone;
                            end
                        end else if (inc == cfg_start) begin
                            dir_n = 1'b1;
                            inc_n = up_tone;
                        end else begin
                            inc_n = dn_tone;
                        end
                    end
                end

                default: state_n = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            inc       <= '0;
            inc_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            dir       <= 1'b1;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            inc       <= inc_n;
            inc_valid <= inc_valid_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            dir       <= dir_n;
            cnt       <= cnt_n;
        end
    end

    // NOTE: config registers carry no reset; they are only read in RUN, which is entered solely via a capture.
    always_ff @(posedge clk) begin
        if (cfg_load) begin
            cfg_sweep    <= sweep_in;
            cfg_start    <= f_start;
            cfg_stop     <= f_stop;
            cfg_step     <= f_step;
            cfg_dwell_m1 <= dwell_m1_in;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of sweep vectors expanded into a
// per-cycle scoreboard, plus hand sequences for reset, abort and start priority.
module tb_dds_sweep_ctrl;

    localparam int W  = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [1:0]    mode;
    logic [W-1:0]  f_start, f_stop, f_step;
    logic [DW-1:0] dwell;
    logic [W-1:0]  inc;
    logic          inc_valid, busy, done, err, dir;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.W(W), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .inc       (inc),
        .inc_valid (inc_valid),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dir       (dir)
    );

    typedef struct packed {
        logic [W-1:0] inc;
        logic         inc_valid;
        logic         busy;
        logic         done;
        logic         err;
        logic         dir;
    } obs_t;

    typedef struct packed {
        logic [1:0]         mode;
        logic [W-1:0]       f_start;
        logic [W-1:0]       f_stop;
        logic [W-1:0]       f_step;
        logic [DW-1:0]      dwell;
        logic [3:0]         n_tones;
        logic [7:0][W-1:0]  tones;
        logic [7:0]         dirs;
        logic               is_err;
    } vec_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic obs_t mk(input logic [W-1:0] i, input logic v, input logic b,
                                input logic d, input logic e, input logic r);
        obs_t o;
        o.inc = i; o.inc_valid = v; o.busy = b; o.done = d; o.err = e; o.dir = r;
        return o;
    endfunction

    function automatic obs_t idle_obs();
        return mk('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic obs_t sample();
        return mk(inc, inc_valid, busy, done, err, dir);
    endfunction

    function automatic vec_t mk_vec(input logic [1:0] m, input logic [W-1:0] fs, input logic [W-1:0] fe,
                                    input logic [W-1:0] st, input logic [DW-1:0] dw, input int n,
                                    input logic [W-1:0] t0, input logic [W-1:0] t1, input logic [W-1:0] t2,
                                    input logic [W-1:0] t3, input logic [W-1:0] t4, input logic [W-1:0] t5,
                                    input logic [W-1:0] t6, input logic [W-1:0] t7,
                                    input logic [7:0] dirs, input logic is_err);
        vec_t v;
        v.mode = m; v.f_start = fs; v.f_stop = fe; v.f_step = st; v.dwell = dw;
        v.n_tones = 4'(n);
        v.tones[0] = t0; v.tones[1] = t1; v.tones[2] = t2; v.tones[3] = t3;
        v.tones[4] = t4; v.tones[5] = t5; v.tones[6] = t6; v.tones[7] = t7;
        v.dirs = dirs; v.is_err = is_err;
        return v;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got inc=%h v=%0b busy=%0b done=%0b err=%0b dir=%0b, expected inc=%h v=%0b busy=%0b done=%0b err=%0b dir=%0b",
                     name, $time, act.inc, act.inc_valid, act.busy, act.done, act.err, act.dir,
                     exp.inc, exp.inc_valid, exp.busy, exp.done, exp.err, exp.dir);
        end
    endtask

    // Pops the next expected cycle and compares it with what the DUT shows now.
    task automatic step_check(input string name);
        obs_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s @%0t: scoreboard empty, got inc=%h", name, $time, inc);
        end else begin
            e = exp_q.pop_front();
            check(name, sample(), e);
        end
    endtask

    task automatic drive_cfg(input vec_t v);
        mode = v.mode; f_start = v.f_start; f_stop = v.f_stop; f_step = v.f_step; dwell = v.dwell;
    endtask

    // Repeat modes keep start high through the run (must be ignored) and end with abort.
    task automatic run_vec(input vec_t v, input string name);
        int  deff   = (v.dwell == '0) ? 1 : int'(v.dwell);
        bit  rep    = (v.mode == 2'b01) || (v.mode == 2'b10);
        int  n_tone = int'(v.n_tones) * deff;
        int  total;
        @(negedge clk);
        drive_cfg(v);
        start = 1'b1;
        abort = 1'b0;
        if (v.is_err) begin
            exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
            exp_q.push_back(idle_obs());
        end else begin
            for (int k = 0; k < int'(v.n_tones); k++)
                for (int j = 0; j < deff; j++)
                    exp_q.push_back(mk(v.tones[k], 1'b1, 1'b1, 1'b0, 1'b0, v.dirs[k]));
            if (!rep) exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
            exp_q.push_back(idle_obs());
            exp_q.push_back(idle_obs());
        end
        total = exp_q.size();
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            step_check(name);
            if (!rep || v.is_err) start = 1'b0;
            if (c == 0) begin
                mode    = 2'($urandom);
                f_start = $urandom;
                f_stop  = $urandom;
                f_step  = '0;
                dwell   = 16'($urandom);
            end
            if (rep && !v.is_err) begin
                if (c == n_tone - 1) abort = 1'b1;
                if (c == n_tone) begin
                    abort = 1'b0;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk_vec(2'b00, 100, 130, 10, 3, 4, 100, 110, 120, 130, 0, 0, 0, 0, 8'hFF, 1'b0);
        vecs[1]  = mk_vec(2'b00, 0, 25, 10, 0, 4, 0, 10, 20, 25, 0, 0, 0, 0, 8'hFF, 1'b0);
        vecs[2]  = mk_vec(2'b10, 0, 20, 10, 2, 8, 0, 10, 20, 10, 0, 10, 20, 10, 8'b0110_0111, 1'b0);
        vecs[3]  = mk_vec(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 2,
                          32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 8'hFF, 1'b0);
        vecs[4]  = mk_vec(2'b00, 50, 60, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 1'b1);
        vecs[5]  = mk_vec(2'b01, 70, 60, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 1'b1);
        vecs[6]  = mk_vec(2'b01, 5, 15, 5, 1, 5, 5, 10, 15, 5, 10, 0, 0, 0, 8'hFF, 1'b0);
        vecs[7]  = mk_vec(2'b11, 7, 7, 3, 2, 1, 7, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 1'b0);
        vecs[8]  = mk_vec(2'b01, 42, 42, 1, 1, 4, 42, 42, 42, 42, 0, 0, 0, 0, 8'hFF, 1'b0);
        vecs[9]  = mk_vec(2'b10, 0, 20, 30, 1, 5, 0, 20, 0, 20, 0, 0, 0, 0, 8'b0000_1011, 1'b0);
        vecs[10] = mk_vec(2'b01, 0, 25, 10, 1, 6, 0, 10, 20, 25, 0, 10, 0, 0, 8'hFF, 1'b0);

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        mode = '0; f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        repeat (3) @(negedge clk);
        exp_q.push_back(idle_obs());
        step_check("reset_state");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // abort and start on the same edge: abort wins, nothing starts
        @(negedge clk);
        drive_cfg(vecs[0]);
        start = 1'b1;
        abort = 1'b1;
        exp_q.push_back(idle_obs());
        @(negedge clk);
        step_check("abort_over_start");
        start = 1'b0;
        abort = 1'b0;
        exp_q.push_back(idle_obs());
        @(negedge clk);
        step_check("abort_over_start_after");

        // rst mid-sweep, then a fresh start restarts at f_start
        @(negedge clk);
        drive_cfg(vecs[0]);
        start = 1'b1;
        exp_q.push_back(mk(100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            step_check("pre_rst_run");
            start = 1'b0;
        end
        rst = 1'b1;
        exp_q.push_back(idle_obs());
        @(negedge clk);
        step_check("rst_mid_sweep");
        rst = 1'b0;
        exp_q.push_back(idle_obs());
        @(negedge clk);
        step_check("rst_no_residual");
        run_vec(vecs[0], "restart_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
